// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU and its sequencing stage.
package alu_pkg;

  // ALU opcode encoding, shared with the ALU itself.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NEG = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_LDI = 3'b111
  } alu_op_t;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } ctrl_state_t;

  // Only the arithmetic ops produce a meaningful carry-out.
  function automatic logic op_writes_carry(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Sequencing/register stage in front of the datapath ALU: instruction
// handshake, operand latch, accumulator, and C/Z/N flag generation.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [DATA_WIDTH-1:0] instr_operand,
  input  logic                  instr_use_carry,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_cin,
  output logic [2:0]            alu_op,
  output logic                  alu_alue,
  input  logic [DATA_WIDTH-1:0] alu_r,
  input  logic                  alu_cout,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  done
);

  ctrl_state_t           r_state;
  ctrl_state_t           w_next;
  logic                  w_accept;
  alu_op_t               r_op;
  logic [DATA_WIDTH-1:0] r_operand;
  logic                  r_use_carry;
  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_c;
  logic                  r_z;
  logic                  r_n;
  logic [DATA_WIDTH-1:0] w_result;

  // State register; reset returns to IDLE and abandons any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-state control outputs.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    instr_ready = 1'b0;
    alu_alue    = 1'b0;
    alu_cin     = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_accept = 1'b1;
          w_next   = EXEC;
        end
      end
      EXEC: begin
        alu_alue = (r_op != ALU_LDI);
        alu_cin  = r_use_carry & r_c;
        w_next   = WB;
      end
      WB: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Instruction latch; inputs are only captured on an IDLE handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= ALU_ADD;
      r_operand   <= '0;
      r_use_carry <= 1'b0;
    end else if (w_accept) begin
      r_op        <= alu_op_t'(instr_op);
      r_operand   <= instr_operand;
      r_use_carry <= instr_use_carry;
    end
  end

  // LDI bypasses the ALU; the result bus is only read while it is enabled.
  always_comb begin
    w_result = (r_op == ALU_LDI) ? r_operand : alu_r;
  end

  // Accumulator and flags commit at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_acc <= w_result;
      if (op_writes_carry(r_op)) r_c <= alu_cout;
      r_z   <= (w_result == '0);
      r_n   <= w_result[DATA_WIDTH-1];
    end
  end

  assign alu_a  = r_acc;
  assign alu_b  = r_operand;
  assign alu_op = r_op;
  assign acc    = r_acc;
  assign flag_c = r_c;
  assign flag_z = r_z;
  assign flag_n = r_n;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with a behavioural ALU on the result bus.
module tb_alu_ctrl;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [W-1:0] instr_operand;
  logic         instr_use_carry;
  logic [W-1:0] alu_a, alu_b, alu_r, acc;
  logic         alu_cin, alu_alue, alu_cout;
  logic [2:0]   alu_op;
  logic         flag_c, flag_z, flag_n, done;
  logic [W:0]   alu_full;

  alu_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_operand(instr_operand),
    .instr_use_carry(instr_use_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_alue(alu_alue), .alu_r(alu_r), .alu_cout(alu_cout),
    .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] acc;
    logic         c;
    logic         z;
    logic         n;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   acc_cyc_q[$];
  int   done_cyc_q[$];
  int   cyc = 0;
  int   alue_cycles = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [W-1:0] m_acc;
  logic         m_c;

  // Reference ALU: {carry/borrow, result}
  function automatic logic [W:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cin);
    logic [W-1:0] neg;
    neg = '0 - a;
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      3'b001:  return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b100:  return {1'b0, neg};
      3'b101:  return {1'b0, a << 1};
      3'b110:  return {1'b0, a >> 1};
      default: return {1'b0, b};
    endcase
  endfunction

  // External ALU: garbage on the bus whenever it is not enabled
  assign alu_full = alu_fn(alu_op, alu_a, alu_b, alu_cin);
  assign alu_r    = alu_alue ? alu_full[W-1:0] : 8'hA5;
  assign alu_cout = alu_alue ? alu_full[W] : 1'b1;

  // Observe handshakes, done pulses and bus-enable cycles
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready) acc_cyc_q.push_back(cyc);
    if (done) begin
      obs_q.push_back(res_t'{acc, flag_c, flag_z, flag_n});
      done_cyc_q.push_back(cyc);
    end
    if (alu_alue) alue_cycles++;
    cyc++;
  end

  task automatic model_op(input logic [2:0] op, input logic [W-1:0] b, input logic uc);
    logic [W:0] t;
    res_t e;
    t = alu_fn(op, m_acc, b, uc & m_c);
    if (op == 3'b000 || op == 3'b001) m_c = t[W];
    m_acc = t[W-1:0];
    e.acc = m_acc; e.c = m_c; e.z = (m_acc == '0); e.n = m_acc[W-1];
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] b, input logic uc,
                      output logic ex_alue, output logic ex_cin);
    int n;
    model_op(op, b, uc);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_operand = b; instr_use_carry = uc;
    n = 0;
    while (!instr_ready && n < 8) begin @(negedge clk); n++; end
    @(negedge clk);
    ex_alue = alu_alue; ex_cin = alu_cin;
    instr_valid = 1'b0; instr_op = 3'b011; instr_operand = 8'h5A; instr_use_carry = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); done_cyc_q.delete();
    m_acc = '0; m_c = 1'b0;
  endtask

  task automatic test_reset();
    logic xa, xc;
    res_t e, o;
    send(3'b111, 8'h80, 1'b0, xa, xc);
    e = exp_q.pop_front();
    n_chk++;
    if (obs_q.size() == 0) begin
      n_fail++; $display("FAIL reset_pre_ldi: no done pulse, required acc=%h", e.acc);
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        n_fail++; $display("FAIL reset_pre_ldi: got acc=%h czn=%b%b%b required acc=%h czn=%b%b%b",
                           o.acc, o.c, o.z, o.n, e.acc, e.c, e.z, e.n);
      end
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_sb();
    n_chk++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h required 00", acc); end
    n_chk++; if ({flag_c, flag_z, flag_n} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got czn=%b%b%b required 000", flag_c, flag_z, flag_n); end
    n_chk++; if (alu_alue !== 1'b0) begin n_fail++; $display("FAIL reset_alue: got %b required 0", alu_alue); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", instr_ready); end
    @(negedge clk);
    n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_next: got %b required 1", instr_ready); end
  endtask

  task automatic test_ldi_add();
    logic ex_alue0, ex_alue1, xc;
    int   alue0, a, d;
    res_t e, o;
    alue0 = alue_cycles;
    send(3'b111, 8'h3C, 1'b0, ex_alue0, xc);
    send(3'b000, 8'hC8, 1'b0, ex_alue1, xc);
    n_chk++; if (ex_alue0 !== 1'b0) begin n_fail++; $display("FAIL ldi_alue: got %b required 0", ex_alue0); end
    n_chk++; if (ex_alue1 !== 1'b1) begin n_fail++; $display("FAIL add_alue: got %b required 1", ex_alue1); end
    n_chk++; if (alue_cycles - alue0 !== 1) begin
      n_fail++; $display("FAIL ldi_add_alue_cycles: got %0d required 1", alue_cycles - alue0); end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL ldi_add_result[%0d]: no done pulse, required acc=%h", i, e.acc);
      end else begin
        o = obs_q.pop_front();
        a = acc_cyc_q.pop_front(); d = done_cyc_q.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL ldi_add_result[%0d]: got acc=%h czn=%b%b%b required acc=%h czn=%b%b%b",
                             i, o.acc, o.c, o.z, o.n, e.acc, e.c, e.z, e.n);
        end
        n_chk++;
        if (d - a !== 2) begin n_fail++; $display("FAIL ldi_add_latency[%0d]: got %0d required 2", i, d - a); end
      end
    end
    n_chk++; if ({acc, flag_c, flag_z, flag_n} !== {8'h04, 3'b100}) begin
      n_fail++; $display("FAIL add_final: got acc=%h czn=%b%b%b required acc=04 czn=100", acc, flag_c, flag_z, flag_n); end
  endtask

  task automatic test_carry_chain();
    logic xa, ex_cin;
    res_t e, o;
    send(3'b000, 8'h01, 1'b1, xa, ex_cin);
    n_chk++; if (ex_cin !== 1'b1) begin n_fail++; $display("FAIL carry_cin: got %b required 1", ex_cin); end
    e = exp_q.pop_front();
    n_chk++;
    if (obs_q.size() == 0) begin
      n_fail++; $display("FAIL carry_result: no done pulse, required acc=%h", e.acc);
    end else begin
      o = obs_q.pop_front(); void'(acc_cyc_q.pop_front()); void'(done_cyc_q.pop_front());
      if (o !== e || o.acc !== 8'h06 || o.c !== 1'b0) begin
        n_fail++; $display("FAIL carry_result: got acc=%h c=%b required acc=06 c=0", o.acc, o.c);
      end
    end
  endtask

  task automatic test_sub();
    logic xa, xc;
    res_t e, o;
    res_t fixed [2];
    fixed[0] = res_t'{8'h00, 1'b0, 1'b1, 1'b0};
    fixed[1] = res_t'{8'hFF, 1'b1, 1'b0, 1'b1};
    send(3'b001, 8'h06, 1'b0, xa, xc);
    send(3'b001, 8'h01, 1'b0, xa, xc);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL sub_result[%0d]: no done pulse, required acc=%h", i, fixed[i].acc);
      end else begin
        o = obs_q.pop_front(); void'(acc_cyc_q.pop_front()); void'(done_cyc_q.pop_front());
        if (o !== e || o !== fixed[i]) begin
          n_fail++; $display("FAIL sub_result[%0d]: got acc=%h czn=%b%b%b required acc=%h czn=%b%b%b",
                             i, o.acc, o.c, o.z, o.n, fixed[i].acc, fixed[i].c, fixed[i].z, fixed[i].n);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int   a, d;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op = (i % 3 == 0) ? 3'b000 : 3'b011;
      instr_operand = 8'h10 + 8'(i);
      instr_use_carry = (i % 3 != 0);
      if (i % 3 == 0) model_op(3'b000, 8'h10 + 8'(i), 1'b0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (acc_cyc_q.size() !== 3) begin
      n_fail++; $display("FAIL b2b_accepts: got %0d required 3", acc_cyc_q.size());
    end else begin
      n_chk++;
      if (acc_cyc_q[1] - acc_cyc_q[0] !== 3 || acc_cyc_q[2] - acc_cyc_q[1] !== 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d,%0d required 3,3",
                           acc_cyc_q[1] - acc_cyc_q[0], acc_cyc_q[2] - acc_cyc_q[1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0 || acc_cyc_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_result[%0d]: no done pulse, required acc=%h", i, e.acc);
      end else begin
        o = obs_q.pop_front(); a = acc_cyc_q.pop_front(); d = done_cyc_q.pop_front();
        if (o !== e || d - a !== 2) begin
          n_fail++; $display("FAIL b2b_result[%0d]: got acc=%h czn=%b%b%b lat=%0d required acc=%h czn=%b%b%b lat=2",
                             i, o.acc, o.c, o.z, o.n, d - a, e.acc, e.c, e.z, e.n);
        end
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0]   ops [8] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
    logic [W-1:0] bs  [8] = '{8'hD0, 8'h0C, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    logic xa, xc;
    res_t e, o;
    for (int i = 0; i < 8; i++) send(ops[i], bs[i], 1'b0, xa, xc);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_chk++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL ops_result[%0d]: no done pulse, required acc=%h", i, e.acc);
      end else begin
        o = obs_q.pop_front(); void'(acc_cyc_q.pop_front()); void'(done_cyc_q.pop_front());
        if (o !== e) begin
          n_fail++; $display("FAIL ops_result[%0d] op=%0d: got acc=%h czn=%b%b%b required acc=%h czn=%b%b%b",
                             i, ops[i], o.acc, o.c, o.z, o.n, e.acc, e.c, e.z, e.n);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic xa, xc;
    int   nobs;
    send(3'b111, 8'h20, 1'b0, xa, xc);
    clear_sb();
    m_acc = 8'h20;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b000; instr_operand = 8'h10; instr_use_carry = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    n_chk++; if (alu_alue !== 1'b1) begin n_fail++; $display("FAIL abort_in_exec: alue got %b required 1", alu_alue); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nobs = obs_q.size();
    n_chk++; if (acc !== 8'h00) begin n_fail++; $display("FAIL abort_acc: got %h required 00", acc); end
    n_chk++; if (alu_alue !== 1'b0) begin n_fail++; $display("FAIL abort_alue: got %b required 0", alu_alue); end
    n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle: ready got %b required 1", instr_ready); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b required 0", done); end
    repeat (3) @(negedge clk);
    n_chk++; if (obs_q.size() !== nobs || nobs !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", obs_q.size()); end
    clear_sb();
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_operand = '0; instr_use_carry = 1'b0;
    m_acc = '0; m_c = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ldi_add();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_logic_ops();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing and register stage directly upstream of the datapath ALU. Accepts one instruction at a time through a valid/ready handshake, holds the accumulator and the carry, zero and negative flags, and drives the ALU operand, carry-in, opcode and bus-enable inputs. It captures the ALU result from the tri-stated result bus and the carry-out into the accumulator and flags. It also provides the Z/N flag generation that the ALU itself does not compute.

## Interface

- `DATA_WIDTH`, default 8: width of the accumulator, operand and ALU buses.
- `clk` in 1: clock. One clock only; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: block can accept an instruction. High only in IDLE.
- `instr_op` in 3: opcode (encoding below).
- `instr_operand` in DATA_WIDTH: operand value; becomes ALU `b` or the load value.
- `instr_use_carry` in 1: when set, ALU carry-in is the C flag; otherwise carry-in is 0.
- `alu_a` out DATA_WIDTH: equals acc.
- `alu_b` out DATA_WIDTH: equals the latched operand register.
- `alu_cin` out 1: carry-in to the ALU.
- `alu_op` out 3: latched opcode.
- `alu_alue` out 1: ALU bus enable.
- `alu_r` in DATA_WIDTH: ALU result bus. Tri-stated when `alu_alue`=0.
- `alu_cout` in 1: ALU carry-out.
- `acc` out DATA_WIDTH: accumulator.
- `flag_c`, `flag_z`, `flag_n` out 1 each: carry, zero and negative flags.
- `done` out 1: one-cycle pulse when the accumulator and flags reflect the completed instruction.

## Operation

**Opcodes**
- 000 ADD
- 001 SUB
- 010 AND
- 011 OR
- 100 NEG
- 101 SHL
- 110 SHR
- 111 LDI: load the operand into acc. The ALU is not used.

**State machine:** three states, IDLE → EXEC → WB → IDLE.

- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid`=1, latch `instr_op`, `instr_operand` and `instr_use_carry`, then go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - `alu_alue`=1 unless the op is LDI.
  - `alu_cin` = `instr_use_carry` AND `flag_c`, using the latched use-carry bit and the current C.
  - At the end of the cycle:
    - acc ← `alu_r`, or ← operand for LDI.
    - C ← `alu_cout` for ADD/SUB only. All other ops leave C unchanged.
    - Z ← (new acc == 0).
    - N ← new acc[DATA_WIDTH-1].
    - Go to WB.
- **WB**
  - `done`=1 and `alu_alue`=0.
  - Go to IDLE.

**Rules**
- `alu_r` is sampled only while `alu_alue`=1. Its value at any other time is don't-care and must never reach any register.
- Instruction inputs are ignored outside IDLE. Changing them mid-operation has no effect.
- Arithmetic results wrap modulo 2^DATA_WIDTH. SUB carry is the ALU's (DATA_WIDTH+1)-bit borrow: C=1 when operand > acc (with cin=0).
- `alu_a` and `alu_b` are driven continuously from registers, not only during EXEC.

**Reset**
- Values: acc=0, C=Z=N=0, operand/op registers 0, state IDLE, `alu_alue`=0, `done`=0, `instr_ready`=1 from the first cycle after reset deasserts.
- Reset during EXEC or WB aborts the instruction. No register takes the in-flight result, and `done` does not pulse.
- Reset has priority over every other event, including a simultaneous handshake.

## Timing

- Handshake accepted at edge T: `alu_alue` is high in cycle T..T+1. Acc and flags update at edge T+1, and `done` is high in cycle T+1..T+2.
- Next acceptance is possible at edge T+3. Throughput is one instruction per 3 cycles.
- `instr_valid` held high continuously gives an acceptance every third cycle. `instr_ready` is combinational from state only, with no path from `instr_valid`.
- The ALU path is combinational within EXEC. `alu_op`, `alu_b` and `alu_cin` are stable for the whole EXEC cycle.

## Structure

- **Package `alu_pkg`:**
  - Opcode constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NEG, ALU_SHL, ALU_SHR, ALU_LDI.
  - State encoding: IDLE, EXEC, WB.
  - Shared with the ALU and its future users.
- **Sub-modules:** none. The FSM, operand latch, accumulator and flag logic are one module. Z/N generation is a few gates and stays inline.

## Test plan

All scenarios use DATA_WIDTH=8.

1. **Reset.** Assert `rst` for 2 cycles mid-stream.
   - Afterwards: acc=0x00, C/Z/N=0, `alu_alue`=0, `done`=0.
   - `instr_ready`=1 on the next cycle.
2. **LDI then ADD.** LDI 0x3C, then ADD 0xC8 (use_carry=0).
   - acc=0x04, C=1, Z=0, N=0.
   - `done` is high exactly 2 cycles after each acceptance.
   - `alu_alue` is low during the LDI and high only in the ADD EXEC.
3. **Carry chain.** With C=1, acc=0x04: ADD 0x01 with use_carry=1.
   - `alu_cin`=1; result acc=0x06, C=0.
4. **SUB.** With acc=0x06: SUB 0x06 gives acc=0x00, Z=1, C=0. A following SUB 0x01 gives acc=0xFF, C=1, N=1, Z=0.
5. **Back-to-back handshake.** Hold `instr_valid`=1 for 9 cycles with changing operands.
   - Exactly 3 acceptances, at cycles 0, 3 and 6.
   - Operands presented during EXEC/WB are ignored.
6. **Abort.** Assert `rst` during EXEC of ADD 0x10 with acc=0x20.
   - No `done` pulse.
   - Next cycle: acc=0x00, `alu_alue`=0, state IDLE.
